// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Signal bundle between the IF/MEM stages, the shared memory
//            port and the instruction/data arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if;
    // fetch side
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_ready_o;

    // load/store side
    logic        data_ce_i;
    logic        data_we_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;

    // shared single-port memory
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    // pipeline control
    logic        flush_i;
    logic        stall_req_o;
    logic        bus_err_o;

    // arbiter view
    modport master (
        input  inst_req_i, inst_addr_i,
        input  data_ce_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
        input  bus_rdata_i, bus_ack_i, flush_i,
        output inst_rdata_o, inst_ready_o,
        output data_rdata_o, data_ready_o,
        output bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output stall_req_o, bus_err_o
    );

    // pipeline / memory view
    modport slave (
        output inst_req_i, inst_addr_i,
        output data_ce_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
        output bus_rdata_i, bus_ack_i, flush_i,
        input  inst_rdata_o, inst_ready_o,
        input  data_rdata_o, data_ready_o,
        input  bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  stall_req_o, bus_err_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between instruction fetch and
//            load/store, data first, with an ack watchdog.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master arb
);

    localparam logic [7:0] c_timeout_cnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_bus_ce,     w_bus_ce;
    logic        r_bus_we,     w_bus_we;
    logic [3:0]  r_bus_sel,    w_bus_sel;
    logic [31:0] r_bus_addr,   w_bus_addr;
    logic [31:0] r_bus_wdata,  w_bus_wdata;
    logic [31:0] r_data_rdata, w_data_rdata;
    logic [31:0] r_inst_rdata, w_inst_rdata;
    logic        r_data_ready, w_data_ready;
    logic        r_inst_ready, w_inst_ready;
    logic        r_bus_err,    w_bus_err;
    logic [7:0]  r_wdog,       w_wdog;
    logic        r_inst_flushed, w_inst_flushed;

    logic [7:0]  w_wdog_inc;
    logic        w_timeout;
    logic        w_flush_seen;
    logic        w_stall;

    assign w_wdog_inc   = r_wdog + 8'd1;
    assign w_timeout    = (w_wdog_inc == c_timeout_cnt);
    // A fetch flushed at any point of its transaction must never report ready.
    assign w_flush_seen = r_inst_flushed | arb.flush_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_bus_ce       = r_bus_ce;
        w_bus_we       = r_bus_we;
        w_bus_sel      = r_bus_sel;
        w_bus_addr     = r_bus_addr;
        w_bus_wdata    = r_bus_wdata;
        w_data_rdata   = r_data_rdata;
        w_inst_rdata   = r_inst_rdata;
        w_data_ready   = 1'b0;
        w_inst_ready   = 1'b0;
        w_bus_err      = 1'b0;
        w_wdog         = r_wdog;
        w_inst_flushed = r_inst_flushed;

        case (r_state)
            ST_IDLE: begin
                // Ready-high requester is still presenting the finished access.
                if (arb.data_ce_i && !r_data_ready) begin
                    w_state_nxt    = ST_DATA;
                    w_bus_ce       = 1'b1;
                    w_bus_we       = arb.data_we_i;
                    w_bus_sel      = arb.data_sel_i;
                    w_bus_addr     = arb.data_addr_i;
                    w_bus_wdata    = arb.data_wdata_i;
                    w_wdog         = 8'd0;
                    w_inst_flushed = 1'b0;
                end else if (arb.inst_req_i && !r_inst_ready && !arb.flush_i) begin
                    w_state_nxt    = ST_INST;
                    w_bus_ce       = 1'b1;
                    w_bus_we       = 1'b0;
                    w_bus_sel      = 4'b1111;
                    w_bus_addr     = arb.inst_addr_i;
                    w_bus_wdata    = 32'd0;
                    w_wdog         = 8'd0;
                    w_inst_flushed = 1'b0;
                end
            end

            ST_DATA: begin
                if (arb.bus_ack_i) begin
                    w_data_rdata = arb.bus_rdata_i;
                    w_data_ready = 1'b1;
                    w_bus_ce     = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (w_timeout) begin
                    w_data_rdata = 32'd0;
                    w_data_ready = 1'b1;
                    w_bus_err    = 1'b1;
                    w_bus_ce     = 1'b0;
                    w_wdog       = w_wdog_inc;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_wdog       = w_wdog_inc;
                end
            end

            ST_INST: begin
                if (arb.bus_ack_i) begin
                    if (!w_flush_seen) begin
                        w_inst_rdata = arb.bus_rdata_i;
                        w_inst_ready = 1'b1;
                    end
                    w_bus_ce       = 1'b0;
                    w_inst_flushed = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else if (w_timeout) begin
                    if (!w_flush_seen) begin
                        w_inst_rdata = 32'd0;
                        w_inst_ready = 1'b1;
                    end
                    w_bus_err      = 1'b1;
                    w_bus_ce       = 1'b0;
                    w_wdog         = w_wdog_inc;
                    w_inst_flushed = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_wdog         = w_wdog_inc;
                    w_inst_flushed = w_flush_seen;
                end
            end

            default: begin
                w_bus_ce    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_bus_ce       <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_sel      <= 4'd0;
            r_bus_addr     <= 32'd0;
            r_bus_wdata    <= 32'd0;
            r_data_rdata   <= 32'd0;
            r_inst_rdata   <= 32'd0;
            r_data_ready   <= 1'b0;
            r_inst_ready   <= 1'b0;
            r_bus_err      <= 1'b0;
            r_wdog         <= 8'd0;
            r_inst_flushed <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_bus_ce       <= w_bus_ce;
            r_bus_we       <= w_bus_we;
            r_bus_sel      <= w_bus_sel;
            r_bus_addr     <= w_bus_addr;
            r_bus_wdata    <= w_bus_wdata;
            r_data_rdata   <= w_data_rdata;
            r_inst_rdata   <= w_inst_rdata;
            r_data_ready   <= w_data_ready;
            r_inst_ready   <= w_inst_ready;
            r_bus_err      <= w_bus_err;
            r_wdog         <= w_wdog;
            r_inst_flushed <= w_inst_flushed;
        end
    end

    assign w_stall = (arb.data_ce_i & ~r_data_ready)
                   | (arb.inst_req_i & ~r_inst_ready & ~arb.flush_i);

    assign arb.stall_req_o  = ~rst & w_stall;
    assign arb.bus_ce_o     = r_bus_ce;
    assign arb.bus_we_o     = r_bus_we;
    assign arb.bus_sel_o    = r_bus_sel;
    assign arb.bus_addr_o   = r_bus_addr;
    assign arb.bus_wdata_o  = r_bus_wdata;
    assign arb.data_rdata_o = r_data_rdata;
    assign arb.inst_rdata_o = r_inst_rdata;
    assign arb.data_ready_o = r_data_ready;
    assign arb.inst_ready_o = r_inst_ready;
    assign arb.bus_err_o    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed and randomized self-checking bench for mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if arb_if ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // transaction-level memory model: ref_mem follows completed requests,
    // bus_mem is what the memory responder serves from the bus signals
    logic [31:0] ref_mem [32];
    logic [31:0] bus_mem [32];

    logic        d_active, d_rel, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr, d_wdata;
    logic        i_active, i_rel;
    logic [31:0] i_addr;
    logic        prev_ce, prev_dr, prev_ir;
    int          lat, grants, d_done, i_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic clear_inputs();
        arb_if.inst_req_i   = 1'b0;
        arb_if.inst_addr_i  = 32'd0;
        arb_if.data_ce_i    = 1'b0;
        arb_if.data_we_i    = 1'b0;
        arb_if.data_sel_i   = 4'd0;
        arb_if.data_addr_i  = 32'd0;
        arb_if.data_wdata_i = 32'd0;
        arb_if.bus_rdata_i  = 32'd0;
        arb_if.bus_ack_i    = 1'b0;
        arb_if.flush_i      = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata);
        arb_if.data_ce_i    = 1'b1;
        arb_if.data_we_i    = we;
        arb_if.data_sel_i   = sel;
        arb_if.data_addr_i  = addr;
        arb_if.data_wdata_i = wdata;
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata);
        chk1({tag, "_ce"}, arb_if.bus_ce_o, 1'b1);
        chk1({tag, "_we"}, arb_if.bus_we_o, we);
        chk({tag, "_sel"}, {28'd0, arb_if.bus_sel_o}, {28'd0, sel});
        chk({tag, "_addr"}, arb_if.bus_addr_o, addr);
        chk({tag, "_wdata"}, arb_if.bus_wdata_o, wdata);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_ce"}, arb_if.bus_ce_o, 1'b0);
        chk1({tag, "_we"}, arb_if.bus_we_o, 1'b0);
        chk({tag, "_sel"}, {28'd0, arb_if.bus_sel_o}, 32'd0);
        chk({tag, "_addr"}, arb_if.bus_addr_o, 32'd0);
        chk({tag, "_wdata"}, arb_if.bus_wdata_o, 32'd0);
        chk({tag, "_drdata"}, arb_if.data_rdata_o, 32'd0);
        chk({tag, "_irdata"}, arb_if.inst_rdata_o, 32'd0);
        chk1({tag, "_dready"}, arb_if.data_ready_o, 1'b0);
        chk1({tag, "_iready"}, arb_if.inst_ready_o, 1'b0);
        chk1({tag, "_err"}, arb_if.bus_err_o, 1'b0);
    endtask

    // One cycle of randomized pipeline + memory behaviour, called at posedge+1.
    task automatic rand_step(input bit allow_new);
        logic [4:0] idx;
        if (d_rel) begin d_active = 1'b0; d_rel = 1'b0; end
        if (i_rel) begin i_active = 1'b0; i_rel = 1'b0; end
        if (allow_new && !d_active && $urandom_range(0, 2) == 0) begin
            d_active = 1'b1;
            d_we     = 1'($urandom_range(0, 1));
            d_sel    = d_we ? 4'($urandom_range(1, 15)) : 4'hF;
            d_addr   = 32'(4 * $urandom_range(0, 15));
            d_wdata  = $urandom;
        end
        if (allow_new && !i_active && $urandom_range(0, 1) == 0) begin
            i_active = 1'b1;
            i_addr   = 32'h1FC0_0040 + 32'(4 * $urandom_range(0, 15));
        end
        arb_if.data_ce_i    = d_active;
        arb_if.data_we_i    = d_we;
        arb_if.data_sel_i   = d_sel;
        arb_if.data_addr_i  = d_addr;
        arb_if.data_wdata_i = d_wdata;
        arb_if.inst_req_i   = i_active;
        arb_if.inst_addr_i  = i_addr;
        arb_if.flush_i      = 1'b0;

        if (arb_if.bus_ce_o && !prev_ce) begin
            grants++;
            lat = $urandom_range(0, 2);
        end
        prev_ce = arb_if.bus_ce_o;

        idx = arb_if.bus_addr_o[6:2];
        if (arb_if.bus_ce_o && lat == 0) begin
            arb_if.bus_ack_i   = 1'b1;
            arb_if.bus_rdata_i = bus_mem[idx];
            if (arb_if.bus_we_o)
                bus_mem[idx] = merge(bus_mem[idx], arb_if.bus_wdata_o, arb_if.bus_sel_o);
        end else begin
            arb_if.bus_ack_i   = 1'b0;
            arb_if.bus_rdata_i = $urandom;
            if (arb_if.bus_ce_o) lat--;
        end

        if (arb_if.data_ready_o) begin
            chk1("rnd_d_owner", d_active, 1'b1);
            chk1("rnd_d_pulse", prev_dr, 1'b0);
            if (!d_we) chk("rnd_d_rdata", arb_if.data_rdata_o, ref_mem[d_addr[6:2]]);
            else ref_mem[d_addr[6:2]] = merge(ref_mem[d_addr[6:2]], d_wdata, d_sel);
            d_done++;
            d_rel = 1'b1;
        end
        prev_dr = arb_if.data_ready_o;

        if (arb_if.inst_ready_o) begin
            chk1("rnd_i_owner", i_active, 1'b1);
            chk1("rnd_i_pulse", prev_ir, 1'b0);
            chk("rnd_i_rdata", arb_if.inst_rdata_o, ref_mem[i_addr[6:2]]);
            i_done++;
            i_rel = 1'b1;
        end
        prev_ir = arb_if.inst_ready_o;

        chk1("rnd_no_err", arb_if.bus_err_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        clear_inputs();
        arb_if.data_ce_i = 1'b1;
        repeat (3) tick();
        chk1("rst_stall", arb_if.stall_req_o, 1'b0);
        chk_all_zero("rst");
        arb_if.data_ce_i = 1'b0;
        rst = 1'b0;
        tick();

        // ---------------- simultaneous requests: data wins ----------------
        arb_if.inst_req_i  = 1'b1;
        arb_if.inst_addr_i = 32'h1FC0_0000;
        data_req(1'b0, 4'hF, 32'h0000_0010, 32'd0);
        settle();
        chk1("sim_stall", arb_if.stall_req_o, 1'b1);
        tick();
        chk_bus("sim_dgrant", 1'b0, 4'hF, 32'h0000_0010, 32'd0);
        tick();
        chk1("sim_hold_ce", arb_if.bus_ce_o, 1'b1);
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'hDEAD_BEEF;
        tick();
        arb_if.bus_ack_i   = 1'b0;
        arb_if.bus_rdata_i = 32'd0;
        chk1("sim_dready", arb_if.data_ready_o, 1'b1);
        chk("sim_drdata", arb_if.data_rdata_o, 32'hDEAD_BEEF);
        chk1("sim_ce_gap", arb_if.bus_ce_o, 1'b0);
        settle();
        chk1("sim_stall_inst", arb_if.stall_req_o, 1'b1);
        tick();
        chk1("sim_dready_end", arb_if.data_ready_o, 1'b0);
        chk_bus("sim_igrant", 1'b0, 4'hF, 32'h1FC0_0000, 32'd0);
        arb_if.data_ce_i   = 1'b0;
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'h3C08_BFC0;
        tick();
        chk1("sim_iready", arb_if.inst_ready_o, 1'b1);
        chk("sim_irdata", arb_if.inst_rdata_o, 32'h3C08_BFC0);
        chk("sim_drdata_held", arb_if.data_rdata_o, 32'hDEAD_BEEF);
        arb_if.inst_req_i = 1'b0;
        arb_if.bus_ack_i  = 1'b0;
        tick();
        chk1("sim_iready_end", arb_if.inst_ready_o, 1'b0);
        chk1("sim_idle_ce", arb_if.bus_ce_o, 1'b0);

        // ---------------- store, ack in the 4th bus cycle ----------------
        data_req(1'b1, 4'b0100, 32'h0000_0020, 32'h00AB_0000);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk_bus("st_hold", 1'b1, 4'b0100, 32'h0000_0020, 32'h00AB_0000);
            chk1("st_no_ready", arb_if.data_ready_o, 1'b0);
            if (i == 4) begin
                arb_if.bus_ack_i   = 1'b1;
                arb_if.bus_rdata_i = 32'h1234_5678;
            end
            tick();
        end
        arb_if.bus_ack_i = 1'b0;
        chk1("st_ready", arb_if.data_ready_o, 1'b1);
        chk("st_rdata", arb_if.data_rdata_o, 32'h1234_5678);
        chk1("st_ce_drop", arb_if.bus_ce_o, 1'b0);
        chk1("st_ack_beats_timeout", arb_if.bus_err_o, 1'b0);
        settle();
        chk1("st_stall_in_pulse", arb_if.stall_req_o, 1'b0);
        arb_if.data_ce_i = 1'b0;
        arb_if.data_we_i = 1'b0;
        tick();
        chk1("st_ready_once", arb_if.data_ready_o, 1'b0);
        chk1("st_no_regrant", arb_if.bus_ce_o, 1'b0);

        // ---------------- flush during a fetch ----------------
        arb_if.inst_req_i  = 1'b1;
        arb_if.inst_addr_i = 32'h1FC0_0040;
        tick();
        chk_bus("fl_grant", 1'b0, 4'hF, 32'h1FC0_0040, 32'd0);
        arb_if.flush_i = 1'b1;
        settle();
        chk1("fl_stall", arb_if.stall_req_o, 1'b0);
        tick();
        arb_if.flush_i = 1'b0;
        chk1("fl_ce_hold1", arb_if.bus_ce_o, 1'b1);
        tick();
        chk1("fl_ce_hold2", arb_if.bus_ce_o, 1'b1);
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'h1111_1111;
        tick();
        arb_if.bus_ack_i = 1'b0;
        chk1("fl_no_iready", arb_if.inst_ready_o, 1'b0);
        chk1("fl_ce_drop", arb_if.bus_ce_o, 1'b0);
        arb_if.flush_i     = 1'b1;
        arb_if.inst_addr_i = 32'h1FC0_0080;
        tick();
        chk1("fl_no_grant_in_flush", arb_if.bus_ce_o, 1'b0);
        arb_if.flush_i = 1'b0;
        tick();
        chk_bus("fl_refetch", 1'b0, 4'hF, 32'h1FC0_0080, 32'd0);
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'h2222_2222;
        tick();
        chk1("fl_refetch_ready", arb_if.inst_ready_o, 1'b1);
        chk("fl_refetch_rdata", arb_if.inst_rdata_o, 32'h2222_2222);
        arb_if.inst_req_i = 1'b0;
        arb_if.bus_ack_i  = 1'b0;
        tick();

        // ---------------- watchdog timeout (TIMEOUT=4) ----------------
        data_req(1'b0, 4'hF, 32'h0000_0030, 32'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk1("to_ce_hold", arb_if.bus_ce_o, 1'b1);
            chk1("to_no_err", arb_if.bus_err_o, 1'b0);
            chk1("to_no_ready", arb_if.data_ready_o, 1'b0);
            tick();
        end
        chk1("to_ce_drop", arb_if.bus_ce_o, 1'b0);
        chk1("to_err", arb_if.bus_err_o, 1'b1);
        chk1("to_ready", arb_if.data_ready_o, 1'b1);
        chk("to_rdata_zero", arb_if.data_rdata_o, 32'd0);
        arb_if.data_ce_i   = 1'b0;
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'hFFFF_FFFF;
        tick();
        chk1("to_err_pulse", arb_if.bus_err_o, 1'b0);
        chk1("idle_ack_no_ready", arb_if.data_ready_o, 1'b0);
        chk("idle_ack_no_capture", arb_if.data_rdata_o, 32'd0);
        arb_if.bus_ack_i = 1'b0;

        // ---------------- back-to-back loads ----------------
        data_req(1'b0, 4'hF, 32'h0000_0004, 32'd0);
        tick();
        chk_bus("b2b_lw1", 1'b0, 4'hF, 32'h0000_0004, 32'd0);
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'hA1A1_A1A1;
        tick();
        arb_if.bus_ack_i = 1'b0;
        chk1("b2b_lw1_ready", arb_if.data_ready_o, 1'b1);
        chk("b2b_lw1_rdata", arb_if.data_rdata_o, 32'hA1A1_A1A1);
        settle();
        chk1("b2b_stall_low", arb_if.stall_req_o, 1'b0);
        tick();
        chk1("b2b_no_dup", arb_if.bus_ce_o, 1'b0);
        arb_if.data_addr_i = 32'h0000_0008;
        tick();
        chk_bus("b2b_lw2", 1'b0, 4'hF, 32'h0000_0008, 32'd0);
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'hA2A2_A2A2;
        tick();
        arb_if.bus_ack_i  = 1'b0;
        arb_if.data_ce_i  = 1'b0;
        chk1("b2b_lw2_ready", arb_if.data_ready_o, 1'b1);
        chk("b2b_lw2_rdata", arb_if.data_rdata_o, 32'hA2A2_A2A2);
        tick();

        // ---------------- reset in DATA with a same-cycle ack ----------------
        data_req(1'b1, 4'b0011, 32'h0000_003C, 32'hCAFE_F00D);
        tick();
        chk_bus("rs_grant", 1'b1, 4'b0011, 32'h0000_003C, 32'hCAFE_F00D);
        arb_if.bus_ack_i   = 1'b1;
        arb_if.bus_rdata_i = 32'h0000_0055;
        rst = 1'b1;
        tick();
        chk_all_zero("rs_mid");
        rst = 1'b0;
        arb_if.data_ce_i = 1'b0;
        tick();
        chk1("rs_late_ack_ready", arb_if.data_ready_o, 1'b0);
        chk("rs_late_ack_rdata", arb_if.data_rdata_o, 32'd0);
        chk1("rs_idle_ce", arb_if.bus_ce_o, 1'b0);
        clear_inputs();
        tick();

        // ---------------- randomized traffic against the memory model ----------------
        for (int k = 0; k < 32; k++) begin
            ref_mem[k] = $urandom;
            bus_mem[k] = ref_mem[k];
        end
        d_active = 1'b0; d_rel = 1'b0; d_we = 1'b0; d_sel = 4'hF;
        d_addr = 32'd0; d_wdata = 32'd0;
        i_active = 1'b0; i_rel = 1'b0; i_addr = 32'h1FC0_0040;
        prev_ce = 1'b0; prev_dr = 1'b0; prev_ir = 1'b0;
        lat = 0; grants = 0; d_done = 0; i_done = 0;

        for (int c = 0; c < 600; c++) begin
            rand_step(1'b1);
            tick();
        end
        for (int c = 0; c < 60; c++) begin
            rand_step(1'b0);
            tick();
            if (!d_active && !i_active && !d_rel && !i_rel) break;
        end
        chk1("rnd_drain_data", d_active, 1'b0);
        chk1("rnd_drain_inst", i_active, 1'b0);
        chk("rnd_one_txn_per_req", grants, d_done + i_done);
        chk1("rnd_data_progress", d_done > 50, 1'b1);
        chk1("rnd_inst_progress", i_done > 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk is the only clock; rst is synchronous, active-high.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port inst_req_i, input, 1, fetch request from IF.
REQ-005 SHALL have port inst_addr_i, input, 32, fetch address.
REQ-006 SHALL have port inst_rdata_o, output, 32, fetched word.
REQ-007 SHALL have port inst_ready_o, output, 1, one-cycle pulse: inst_rdata_o valid.
REQ-008 SHALL have port data_ce_i, input, 1, data request from MEM, same meaning as MEM's mem_ce_o.
REQ-009 SHALL have ports data_we_i (input, 1), data_sel_i (input, 4), data_addr_i (input, 32) and data_wdata_i (input, 32): MEM's write enable, byte select, physical address and store data.
REQ-010 SHALL have port data_rdata_o, output, 32, load word returned to MEM.
REQ-011 SHALL have port data_ready_o, output, 1, one-cycle pulse: data access complete.
REQ-012 SHALL have ports bus_ce_o (output, 1), bus_we_o (output, 1), bus_sel_o (output, 4), bus_addr_o (output, 32) and bus_wdata_o (output, 32): the shared single-port memory request.
REQ-013 SHALL have port bus_rdata_i, input, 32, memory read data, valid with bus_ack_i.
REQ-014 SHALL have port bus_ack_i, input, 1, memory completion strobe.
REQ-015 SHALL have port flush_i, input, 1, exception/branch flush from CP0/ID.
REQ-016 SHALL have port stall_req_o, output, 1, pipeline stall request to the stall controller.
REQ-017 SHALL have port bus_err_o, output, 1, one-cycle pulse on watchdog timeout.
REQ-018 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for bus_ack_i (8-bit counter).

Function
REQ-019 SHALL implement the three states IDLE, DATA and INST.
REQ-020 SHALL, in IDLE, grant data first: if data_ce_i=1 and data_ready_o=0, it SHALL go to DATA; else if inst_req_i=1, inst_ready_o=0 and flush_i=0, it SHALL go to INST; otherwise it SHALL stay in IDLE.
REQ-021 SHALL, on a grant, register the bus outputs at that edge and hold them stable until the cycle bus_ack_i is sampled: DATA drives data_we_i, data_sel_i, data_addr_i and data_wdata_i; INST drives we=0, sel=4'b1111, inst_addr_i and wdata=0.
REQ-022 SHALL keep bus_ce_o=1 only while in DATA or INST.
REQ-023 SHALL, when bus_ack_i=1 in DATA, at that edge capture bus_rdata_i into data_rdata_o, pulse data_ready_o for the next cycle, clear bus_ce_o and return to IDLE.
REQ-024 SHALL, when bus_ack_i=1 in INST, at that edge capture bus_rdata_i into inst_rdata_o, pulse inst_ready_o for the next cycle, clear bus_ce_o and return to IDLE.
REQ-025 SHALL hold bus_ce_o low for at least one cycle between transactions, giving a minimum latency of request-to-ready = ack latency + 2 cycles.
REQ-026 SHALL not re-grant a requester in the cycle its ready pulse is high; the other requester may be granted in that cycle.
REQ-027 SHALL drive stall_req_o combinationally as (data_ce_i & ~data_ready_o) | (inst_req_i & ~inst_ready_o & ~flush_i).
REQ-028 SHALL, if flush_i=1 while in INST, let the bus transaction run to completion (no abort) but suppress inst_ready_o for that transaction.
REQ-029 SHALL not alter an in-flight DATA transaction on flush_i.
REQ-030 SHALL ignore bus_ack_i in IDLE.
REQ-031 SHALL clear the watchdog counter on every grant and increment it each cycle in DATA/INST without ack.
REQ-032 SHALL, when the watchdog counter reaches TIMEOUT, return to IDLE, clear bus_ce_o, pulse bus_err_o, and pulse the owning ready with rdata=32'h0 (the INST ready stays suppressed if flushed).
REQ-033 SHALL treat ack and timeout in the same cycle as ack; bus_err_o stays 0.
REQ-034 SHALL keep data_rdata_o and inst_rdata_o held until the next capture.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, enter IDLE and zero bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, data_rdata_o, inst_rdata_o, data_ready_o, inst_ready_o, bus_err_o and the watchdog counter.
REQ-036 SHALL, on reset mid-transaction, drop the transaction with no ready pulse and ignore any later ack until a new grant.
REQ-037 SHALL hold stall_req_o at 0 while rst=1.

Verification
REQ-038 Simultaneous requests: inst_req_i=1 (0x1FC00000) and data_ce_i=1 (lw, 0x00000010, sel=1111) in the same cycle -> data granted first; ack 2 cycles later -> data_ready_o pulse, data_rdata_o=bus_rdata_i; INST granted the next cycle.
REQ-039 Store: data_we_i=1, sel=0100, wdata=0x00AB0000, ack after 3 cycles -> bus outputs stable for all 4 cycles, data_ready_o one pulse, stall_req_o low in the pulse cycle.
REQ-040 Flush: flush_i=1 one cycle after the INST grant -> bus_ce_o held until ack, inst_ready_o stays 0, new fetch granted only after flush_i=0.
REQ-041 Timeout with TIMEOUT=4 and no ack -> bus_ce_o drops after 4 cycles, bus_err_o pulse, data_ready_o pulse, data_rdata_o=0.
REQ-042 Reset: rst=1 during DATA with ack arriving the same cycle -> no data_ready_o pulse, all outputs 0 the next cycle, state IDLE.
REQ-043 Back-to-back loads held by the pipeline: the second lw follows only after stall_req_o deasserts -> exactly one bus transaction per lw, with no duplicate issue.
